// File: rtl/neuron_weight_loader_pkg.sv
// Shared types for the neuron weight loader: command opcodes,
// FSM state codes and the dout bus slice helper.
package neuron_weight_loader_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_INIT  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD0  = 3'd2;
  localparam logic [2:0] S_RD1  = 3'd3;
  localparam logic [2:0] S_INIT = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  function automatic int slice_lo(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/neuron_weight_loader_if.sv
// Host command/response channel of the neuron weight loader.
// master: host side (drives cmd_*, rsp_ready); slave: the loader.
interface neuron_weight_loader_if #(
  parameter int WEIGHT_SIZE       = 32,
  parameter int WEIGHT_ADDR_WIDTH = 8,
  parameter int NEURON_SEL_WIDTH  = 2
);
  import neuron_weight_loader_pkg::*;

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [1:0]                   cmd_op;
  logic [NEURON_SEL_WIDTH-1:0]  cmd_neuron;
  logic [WEIGHT_ADDR_WIDTH-1:0] cmd_addr;
  logic [WEIGHT_SIZE-1:0]       cmd_data;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [WEIGHT_SIZE-1:0]       rsp_data;
  logic                         rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_neuron,
    output cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_neuron,
    input  cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/neuron_weight_loader_weight_dout_mux.sv
// Combinational select of one neuron's mem_dout slice.
// Ports: bus (all neurons), sel (neuron index), dout (selected word).
module weight_dout_mux
  import neuron_weight_loader_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int WEIGHT_SIZE = 32,
  parameter int SEL_WIDTH   = 2
) (
  input  logic [NUM_NEURONS*WEIGHT_SIZE-1:0] bus,
  input  logic [SEL_WIDTH-1:0]               sel,
  output logic [WEIGHT_SIZE-1:0]             dout
);

  always_comb begin
    dout = '0;
    for (int n = 0; n < NUM_NEURONS; n++)
      if (int'(sel) == n)
        dout = bus[slice_lo(n, WEIGHT_SIZE) +: WEIGHT_SIZE];
  end

endmodule

// File: rtl/neuron_weight_loader.sv
// Host-side initiator for the per-neuron weight memories: single
// write, single read and bulk init over a valid/ready channel.
// Ports: mem_clk, rst (async, active-high), host (cmd/rsp channel),
// mem_addr/mem_din/mem_wen (registered broadcast bus), mem_dout_bus.
// NEURON_WEIGHT_LOADER_VERIFY_EN adds readback checking of writes.
module neuron_weight_loader
  import neuron_weight_loader_pkg::*;
#(
  parameter int NUM_NEURONS       = 4,
  parameter int NUM_INPUTS        = 4,
  parameter int WEIGHT_SIZE       = 32,
  parameter int WEIGHT_ADDR_WIDTH = 8,
  parameter int NEURON_SEL_WIDTH  = 2,
  parameter int INIT_WEIGHT       = 1
) (
  input  logic                                mem_clk,
  input  logic                                rst,
  neuron_weight_loader_if.slave               host,
  output logic [WEIGHT_ADDR_WIDTH-1:0]        mem_addr,
  output logic [WEIGHT_SIZE-1:0]              mem_din,
  output logic [NUM_NEURONS-1:0]              mem_wen,
  input  logic [NUM_NEURONS*WEIGHT_SIZE-1:0]  mem_dout_bus
);

  localparam logic [WEIGHT_ADDR_WIDTH-1:0] LAST_ADDR =
    WEIGHT_ADDR_WIDTH'(NUM_INPUTS - 1);
  localparam logic [NEURON_SEL_WIDTH-1:0] LAST_NEU =
    NEURON_SEL_WIDTH'(NUM_NEURONS - 1);

  logic [2:0]                   state;
  op_e                          op;
  logic [NEURON_SEL_WIDTH-1:0]  neu;
  logic [WEIGHT_SIZE-1:0]       rdata;
  logic                         err;
  logic [WEIGHT_SIZE-1:0]       dout;
  logic                         bad;
  logic                         last_addr;
  logic                         last;
  logic [WEIGHT_ADDR_WIDTH-1:0] nxt_addr;
  logic [NEURON_SEL_WIDTH-1:0]  nxt_neu;

  function automatic logic [NUM_NEURONS-1:0] onehot(
    input logic [NEURON_SEL_WIDTH-1:0] s
  );
    return NUM_NEURONS'(1) << s;
  endfunction

  weight_dout_mux #(
    .NUM_NEURONS (NUM_NEURONS),
    .WEIGHT_SIZE (WEIGHT_SIZE),
    .SEL_WIDTH   (NEURON_SEL_WIDTH)
  ) u_mux (
    .bus  (mem_dout_bus),
    .sel  (neu),
    .dout (dout)
  );

  // INIT ignores the neuron/address fields, so only op is checked.
  assign bad = (host.cmd_op == OP_RSVD) ||
               ((host.cmd_op != OP_INIT) &&
                ((int'(host.cmd_neuron) >= NUM_NEURONS) ||
                 (int'(host.cmd_addr) >= NUM_INPUTS)));

  // INIT walk: mem_addr doubles as the inner index, neu as outer.
  assign last_addr = (mem_addr == LAST_ADDR);
  assign last      = last_addr && (neu == LAST_NEU);
  assign nxt_addr  = last_addr ? '0
                   : mem_addr + WEIGHT_ADDR_WIDTH'(1);
  assign nxt_neu   = last_addr ? neu + NEURON_SEL_WIDTH'(1) : neu;

  assign host.cmd_ready = (state == S_IDLE);
  assign host.rsp_valid = (state == S_RESP);
  assign host.rsp_data  = rdata;
  assign host.rsp_err   = err;

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op       <= OP_WRITE;
      neu      <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_wen  <= '0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (host.cmd_valid) begin
          op    <= op_e'(host.cmd_op);
          neu   <= host.cmd_neuron;
          rdata <= '0;
          err   <= 1'b0;
          if (bad) begin
            err   <= 1'b1;
            state <= S_RESP;
          end else begin
            case (op_e'(host.cmd_op))
              OP_WRITE: begin
                mem_addr <= host.cmd_addr;
                mem_din  <= host.cmd_data;
                mem_wen  <= onehot(host.cmd_neuron);
                state    <= S_WR;
              end
              OP_READ: begin
                mem_addr <= host.cmd_addr;
                state    <= S_RD0;
              end
              default: begin
                neu      <= '0;
                mem_addr <= '0;
                mem_din  <= WEIGHT_SIZE'(INIT_WEIGHT);
                mem_wen  <= NUM_NEURONS'(1);
                state    <= S_INIT;
              end
            endcase
          end
        end
        S_WR: begin
          mem_wen <= '0;
`ifdef NEURON_WEIGHT_LOADER_VERIFY_EN
          state   <= S_RD0;
`else
          state   <= S_RESP;
`endif
        end
        S_INIT: begin
`ifdef NEURON_WEIGHT_LOADER_VERIFY_EN
          mem_wen <= '0;
          state   <= S_RD0;
`else
          if (last) begin
            mem_wen <= '0;
            state   <= S_RESP;
          end else begin
            mem_addr <= nxt_addr;
            neu      <= nxt_neu;
            mem_wen  <= onehot(nxt_neu);
          end
`endif
        end
        S_RD0: state <= S_RD1;
        S_RD1: begin
`ifdef NEURON_WEIGHT_LOADER_VERIFY_EN
          if (op != OP_READ) begin
            // keep the first mismatching word only
            if ((dout != mem_din) && !err) begin
              err   <= 1'b1;
              rdata <= dout;
            end
            if ((op == OP_INIT) && !last) begin
              mem_addr <= nxt_addr;
              neu      <= nxt_neu;
              mem_wen  <= onehot(nxt_neu);
              state    <= S_INIT;
            end else begin
              state <= S_RESP;
            end
          end else
`endif
          begin
            rdata <= dout;
            state <= S_RESP;
          end
        end
        S_RESP: if (host.rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
